// File: rtl/dmem_host_port.sv
// dmem_host_port
//   Host-side access port for the core's data memory. Loads an operand image
//   into DMem before a run and streams result bytes back out afterwards. While
//   it owns the DMem port (any state other than IDLE) it holds the core in
//   reset through core_hold.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   start_load, start_dump  1-cycle requests, sampled in IDLE only
//   base, len               start address and byte count (0..2**AW)
//   in_valid/in_data/in_ready     host -> DMem byte stream (load)
//   out_valid/out_data/out_ready  DMem -> host byte stream (dump)
//   dm_wen/dm_addr/dm_wdat  DMem write/address port
//   dm_rdat                 DMem read data, combinational from dm_addr
//   core_hold, busy         high whenever the port is not IDLE
//   op_done                 1-cycle pulse when a transfer finishes
module dmem_host_port #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_load,
    input  logic          start_dump,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          dm_wen,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdat,
    input  logic [DW-1:0] dm_rdat,
    output logic          core_hold,
    output logic          busy,
    output logic          op_done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FETCH = 3'd2,
        SEND  = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_t        state, state_nxt;
    logic [AW-1:0] ptr, ptr_nxt;
    logic [AW:0]   cnt, cnt_nxt;
    logic [DW-1:0] odata_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            cnt      <= cnt_nxt;
            out_data <= odata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        odata_nxt = out_data;
        unique case (state)
            IDLE: begin
                // load has priority; a simultaneous dump request is dropped
                if (start_load || start_dump) begin
                    ptr_nxt = base;
                    cnt_nxt = len;
                    if (len == '0)
                        state_nxt = FIN;
                    else if (start_load)
                        state_nxt = LOAD;
                    else
                        state_nxt = FETCH;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    ptr_nxt = ptr + PTR_ONE;
                    cnt_nxt = cnt - CNT_ONE;
                    if (cnt == CNT_ONE)
                        state_nxt = FIN;
                end
            end
            FETCH: begin
                odata_nxt = dm_rdat;
                state_nxt = SEND;
            end
            SEND: begin
                // out_data is only reloaded in FETCH, so it holds while stalled
                if (out_ready) begin
                    ptr_nxt   = ptr + PTR_ONE;
                    cnt_nxt   = cnt - CNT_ONE;
                    state_nxt = (cnt == CNT_ONE) ? FIN : FETCH;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == SEND);
    assign dm_wen    = in_ready && in_valid;
    assign dm_addr   = ptr;
    assign dm_wdat   = dm_wen ? in_data : '0;
    assign core_hold = (state != IDLE);
    assign busy      = core_hold;
    assign op_done   = (state == FIN);

endmodule

// File: tb/tb_dmem_host_port.sv
// tb_dmem_host_port
//   Directed bench for dmem_host_port with a behavioural 256-byte DMem behind
//   the dm_* port. Loads, dumps, address wrap, zero length, start contention
//   and a reset in the middle of a load.
module tb_dmem_host_port;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_load, start_dump;
    logic [7:0] base;
    logic [8:0] len;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       dm_wen;
    logic [7:0] dm_addr;
    logic [7:0] dm_wdat;
    logic [7:0] dm_rdat;
    logic       core_hold, busy, op_done;

    int total = 0;
    int bad   = 0;
    int wen_cnt = 0, done_cnt = 0, ov_cnt = 0;

    logic [7:0] mem [256] = '{default: 8'h5A};

    always #5 clk = ~clk;

    dmem_host_port #(.AW(8), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .start_load(start_load), .start_dump(start_dump),
        .base(base), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdat(dm_wdat), .dm_rdat(dm_rdat),
        .core_hold(core_hold), .busy(busy), .op_done(op_done)
    );

    assign dm_rdat = mem[dm_addr];

    always @(posedge clk) begin
        if (dm_wen) begin
            mem[dm_addr] <= dm_wdat;
            wen_cnt <= wen_cnt + 1;
        end
        if (op_done)   done_cnt <= done_cnt + 1;
        if (out_valid) ov_cnt   <= ov_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load d into DMem at b; optional idle gap after byte gap_idx, optionally
    // with a start_dump during that gap; both=1 raises start_dump with the start.
    task automatic do_load(input logic [7:0] b, input logic [7:0] d[$],
                           input int gap_idx, input bit both, input bit dump_in_gap);
        base = b;
        len = 9'(d.size());
        start_load = 1'b1;
        start_dump = both;
        step();
        start_load = 1'b0;
        start_dump = 1'b0;
        chk("ld_hold", core_hold, 1);
        chk("ld_in_ready", in_ready, 1);
        for (int i = 0; i < d.size(); i++) begin
            in_valid = 1'b1;
            in_data = d[i];
            step();
            if (i == gap_idx) begin
                in_valid = 1'b0;
                start_dump = dump_in_gap;
                step();
                start_dump = 1'b0;
                chk("ld_gap_stay", in_ready, 1);
            end
        end
        in_valid = 1'b0;
        chk("ld_fin_done", op_done, 1);
        chk("ld_fin_hold", core_hold, 1);
        step();
        chk("ld_release", core_hold, 0);
        chk("ld_done_clear", op_done, 0);
    endtask

    // Dump l bytes from b into got; hold out_ready low for stall cycles on byte stall_idx.
    task automatic do_dump(input logic [7:0] b, input logic [8:0] l, input int stall_idx,
                           input int stall, output logic [7:0] got[$]);
        int n = 0;
        int guard = 0;
        logic [7:0] hold;
        got.delete();
        base = b;
        len = l;
        start_dump = 1'b1;
        step();
        start_dump = 1'b0;
        chk("dp_hold", core_hold, 1);
        while (!op_done && guard < 200) begin
            if (out_valid) begin
                if (n == stall_idx) begin
                    for (int s = 0; s < stall; s++) begin
                        hold = out_data;
                        step();
                        chk("dp_stall_stable", out_data, hold);
                        chk("dp_stall_valid", out_valid, 1);
                    end
                end
                got.push_back(out_data);
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
                n++;
            end else begin
                step();
            end
            guard++;
        end
        chk("dp_no_timeout", guard < 200, 1);
        step();
        chk("dp_release", core_hold, 0);
    endtask

    initial begin
        logic [7:0] got[$];
        logic [7:0] d[$];
        int w0, dn0, ov0;

        reset = 1'b1;
        start_load = 1'b0; start_dump = 1'b0;
        base = '0; len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step(); step();
        chk("rst_hold", core_hold, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", op_done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_addr", dm_addr, 0);
        chk("rst_wen", dm_wen, 0);
        reset = 1'b0;
        step();

        // T1: load with an in_valid gap after the second byte
        w0 = wen_cnt; dn0 = done_cnt;
        d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        do_load(8'h10, d, 1, 1'b0, 1'b0);
        chk("t1_m10", mem[8'h10], 8'hA1);
        chk("t1_m11", mem[8'h11], 8'hB2);
        chk("t1_m12", mem[8'h12], 8'hC3);
        chk("t1_m13", mem[8'h13], 8'hD4);
        chk("t1_m0f", mem[8'h0F], 8'h5A);
        chk("t1_m14", mem[8'h14], 8'h5A);
        chk("t1_wen_cnt", wen_cnt - w0, 4);
        chk("t1_done_cnt", done_cnt - dn0, 1);

        // T2: dump with a 3-cycle stall on the second byte
        d = '{8'h05, 8'h06, 8'h07};
        do_load(8'h20, d, -1, 1'b0, 1'b0);
        w0 = wen_cnt;
        do_dump(8'h20, 9'd3, 1, 3, got);
        chk("t2_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("t2_b0", got[0], 8'h05);
            chk("t2_b1", got[1], 8'h06);
            chk("t2_b2", got[2], 8'h07);
        end
        chk("t2_no_wen", wen_cnt - w0, 0);

        // T3: address wrap for load and dump
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_load(8'hFE, d, -1, 1'b0, 1'b0);
        chk("t3_mfe", mem[8'hFE], 8'h11);
        chk("t3_mff", mem[8'hFF], 8'h22);
        chk("t3_m00", mem[8'h00], 8'h33);
        chk("t3_m01", mem[8'h01], 8'h44);
        do_dump(8'hFE, 9'd4, -1, 0, got);
        chk("t3_count", got.size(), 4);
        if (got.size() == 4) begin
            chk("t3_b0", got[0], 8'h11);
            chk("t3_b3", got[3], 8'h44);
        end

        // T4: zero-length dump goes straight to FIN
        w0 = wen_cnt; ov0 = ov_cnt;
        base = 8'h30; len = 9'd0;
        start_dump = 1'b1;
        step();
        start_dump = 1'b0;
        chk("t4_done", op_done, 1);
        chk("t4_hold", core_hold, 1);
        chk("t4_out_valid", out_valid, 0);
        step();
        chk("t4_done_clear", op_done, 0);
        chk("t4_release", core_hold, 0);
        chk("t4_no_wen", wen_cnt - w0, 0);
        chk("t4_no_ov", ov_cnt - ov0, 0);

        // T5: load beats a simultaneous dump; start_dump during LOAD is ignored
        ov0 = ov_cnt;
        d = '{8'h91, 8'h92};
        do_load(8'h40, d, -1, 1'b1, 1'b0);
        d = '{8'h93, 8'h94};
        do_load(8'h50, d, 0, 1'b0, 1'b1);
        step(); step();
        chk("t5_idle", core_hold, 0);
        chk("t5_m40", mem[8'h40], 8'h91);
        chk("t5_m41", mem[8'h41], 8'h92);
        chk("t5_m50", mem[8'h50], 8'h93);
        chk("t5_m51", mem[8'h51], 8'h94);
        chk("t5_no_ov", ov_cnt - ov0, 0);

        // T6: reset after 2 of 5 bytes, then a fresh load
        base = 8'h60; len = 9'd5;
        start_load = 1'b1;
        step();
        start_load = 1'b0;
        in_valid = 1'b1; in_data = 8'hE0; step();
        in_data = 8'hE1; step();
        in_data = 8'hE2;
        #1 reset = 1'b1;
        #1;
        chk("t6_hold", core_hold, 0);
        chk("t6_busy", busy, 0);
        chk("t6_wen", dm_wen, 0);
        chk("t6_in_ready", in_ready, 0);
        chk("t6_addr", dm_addr, 0);
        chk("t6_wdat", dm_wdat, 0);
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("t6_m60", mem[8'h60], 8'hE0);
        chk("t6_m61", mem[8'h61], 8'hE1);
        chk("t6_m62", mem[8'h62], 8'h5A);
        chk("t6_m64", mem[8'h64], 8'h5A);
        d = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4};
        do_load(8'h60, d, -1, 1'b0, 1'b0);
        chk("t6_re_m60", mem[8'h60], 8'hF0);
        chk("t6_re_m64", mem[8'h64], 8'hF4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
